// File: rtl/iomem_pkg.sv
// Shared widths, state codes and constants for the iomem initiator.
package iomem_pkg;

  localparam int unsigned IOMEM_ADDR_W = 32;
  localparam int unsigned IOMEM_DATA_W = 32;
  localparam int unsigned IOMEM_STRB_W = 4;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_BUS  = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

  // An all-zero strobe on the bus marks a read cycle.
  localparam logic [IOMEM_STRB_W-1:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/iomem_timeout_ctr.sv
// Bus-cycle watchdog: counts cycles spent waiting for iomem_ready.
module iomem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CTR_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CTR_W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CTR_W'(TIMEOUT_CYCLES - 1);

  logic [CTR_W-1:0] count;

  // Count waiting cycles; saturate at the last value so the counter never wraps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CTR_W'(1);
    end
  end

  // Zero TIMEOUT_CYCLES disables the watchdog entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST);

endmodule

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master with command/response handshakes and timeout.
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [IOMEM_ADDR_W-1:0] cmd_addr,
  input  logic [IOMEM_DATA_W-1:0] cmd_wdata,
  input  logic [IOMEM_STRB_W-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IOMEM_DATA_W-1:0] rsp_rdata,
  output logic                    rsp_error,
  output logic                    iomem_valid,
  output logic [IOMEM_STRB_W-1:0] iomem_wstrb,
  output logic [IOMEM_ADDR_W-1:0] iomem_addr,
  output logic [IOMEM_DATA_W-1:0] iomem_wdata,
  input  logic                    iomem_ready,
  input  logic [IOMEM_DATA_W-1:0] iomem_rdata,
  output logic                    busy
);

  logic [STATE_W-1:0]      state_q, state_d;
  logic                    iomem_valid_d;
  logic [IOMEM_STRB_W-1:0] iomem_wstrb_d;
  logic [IOMEM_ADDR_W-1:0] iomem_addr_d;
  logic [IOMEM_DATA_W-1:0] iomem_wdata_d;
  logic                    rsp_valid_d;
  logic [IOMEM_DATA_W-1:0] rsp_rdata_d;
  logic                    rsp_error_d;
  logic                    ctr_clear;
  logic                    ctr_enable;
  logic                    ctr_expired;

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);

  iomem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .resetn (resetn),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expired(ctr_expired)
  );

  // State and registered outputs; reset drops the bus request immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      iomem_valid <= 1'b0;
      iomem_wstrb <= WSTRB_READ;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
    end else begin
      state_q     <= state_d;
      iomem_valid <= iomem_valid_d;
      iomem_wstrb <= iomem_wstrb_d;
      iomem_addr  <= iomem_addr_d;
      iomem_wdata <= iomem_wdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_error   <= rsp_error_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a transition says otherwise.
  always_comb begin
    state_d       = state_q;
    iomem_valid_d = iomem_valid;
    iomem_wstrb_d = iomem_wstrb;
    iomem_addr_d  = iomem_addr;
    iomem_wdata_d = iomem_wdata;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_error_d   = rsp_error;
    ctr_clear     = 1'b0;
    ctr_enable    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_write && (cmd_wstrb == WSTRB_READ)) begin
            // A write that touches no bytes never reaches the bus.
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
            state_d     = ST_RESP;
          end else begin
            iomem_valid_d = 1'b1;
            iomem_addr_d  = cmd_addr;
            iomem_wdata_d = cmd_wdata;
            iomem_wstrb_d = cmd_write ? cmd_wstrb : WSTRB_READ;
            ctr_clear     = 1'b1;
            state_d       = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        if (iomem_ready) begin
          // Ready beats a simultaneous timeout; valid must fall on this edge.
          iomem_valid_d = 1'b0;
          iomem_wstrb_d = WSTRB_READ;
          rsp_rdata_d   = (iomem_wstrb == WSTRB_READ) ? iomem_rdata : '0;
          rsp_error_d   = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (ctr_expired) begin
          iomem_valid_d = 1'b0;
          iomem_wstrb_d = WSTRB_READ;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          ctr_enable = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Randomized self-checking bench for iomem_initiator with a negedge-driven responder.
module tb_iomem_initiator;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready = 1'b0;
  logic [31:0] iomem_rdata = '0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Responder controls: lat = cycles of valid before ready (0 = never answer).
  int          lat = 0;
  logic [31:0] rsp_val = '0;
  int          pulses = 0;
  int          stray_cnt = 0;
  int          stray_done = 0;
  int          wait_cnt = 0;

  iomem_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .iomem_valid(iomem_valid),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready),
    .iomem_rdata(iomem_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Peripheral model: one-cycle ready pulse after lat cycles of valid, plus injected strays.
  always @(negedge clk) begin
    if (iomem_ready) begin
      iomem_ready = 1'b0;
    end else if (stray_done != stray_cnt) begin
      iomem_ready = 1'b1;
      iomem_rdata = 32'hDEAD_BEEF;
      stray_done  = stray_done + 1;
    end else if (iomem_valid && lat != 0) begin
      wait_cnt = wait_cnt + 1;
      if (wait_cnt == lat) begin
        iomem_ready = 1'b1;
        iomem_rdata = rsp_val;
        wait_cnt    = 0;
        pulses      = pulses + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Offer one command while idle; returns just after the accepting edge.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Full transaction against the reference rules: bus outcome, latency, response, backpressure.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int l, input logic [31:0] rv, input int hold, input bit stray);
    bit          illegal;
    bit          ok;
    int          exp_vcyc;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_wstrb;
    int          vcyc;
    int          j;
    int          p0;
    bit          unstable;
    bit          held_bad;
    logic [31:0] cap_rdata;
    logic        cap_err;

    illegal   = w && (s == 4'b0000);
    ok        = !illegal && (l != 0) && (l <= int'(T));
    exp_vcyc  = illegal ? 0 : (ok ? l : int'(T));
    exp_rdata = (ok && !w) ? rv : 32'd0;
    exp_wstrb = w ? s : 4'b0000;

    lat      = l;
    rsp_val  = rv;
    p0       = pulses;
    vcyc     = 0;
    j        = -1;
    unstable = 1'b0;
    held_bad = 1'b0;

    issue(w, a, d, s);
    for (int k = 0; k < 200 && j < 0; k++) begin
      @(negedge clk);
      if (iomem_valid) begin
        vcyc++;
        if (iomem_addr !== a || iomem_wdata !== d || iomem_wstrb !== exp_wstrb) unstable = 1'b1;
      end
      if (rsp_valid) j = k;
    end
    if (j < 0) begin
      check("rsp_wait_bound", 32'd0, 32'd1);
      return;
    end
    check("valid_cycles", 32'(vcyc), 32'(exp_vcyc));
    check("rsp_latency", 32'(j), 32'(exp_vcyc));
    check("request_stable", 32'(unstable), 32'd0);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_error", 32'(rsp_error), 32'(!ok));
    check("ready_pulses", 32'(pulses - p0), 32'(ok));

    cap_rdata = rsp_rdata;
    cap_err   = rsp_error;
    for (int k = 0; k < hold; k++) begin
      if (stray && k == 1) stray_cnt++;
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== cap_rdata || rsp_error !== cap_err ||
          cmd_ready !== 1'b0 || busy !== 1'b1 || iomem_valid !== 1'b0) held_bad = 1'b1;
    end
    if (hold > 0) check("rsp_held", 32'(held_bad), 32'd0);

    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("idle_after_rsp", 32'({busy, rsp_valid, cmd_ready}), 32'b001);
  endtask

  initial begin
    bit          w;
    logic [3:0]  s;
    logic [31:0] a;

    // Reset state
    #2;
    check("rst_iomem_valid", 32'(iomem_valid), 32'd0);
    check("rst_iomem_wstrb", 32'(iomem_wstrb), 32'd0);
    check("rst_iomem_addr", iomem_addr, 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_error}), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Directed: read, full write, partial write, illegal write
    txn(1'b0, 32'h0300_0000, 32'h0, 4'h0, 2, 32'h0000_00A5, 0, 1'b0);
    txn(1'b1, 32'h0300_0000, 32'h0000_0001, 4'hF, 2, 32'h1234_5678, 0, 1'b0);
    txn(1'b1, 32'h0300_0004, 32'hCAFE_F00D, 4'h2, 3, 32'h0, 0, 1'b0);
    txn(1'b1, 32'h0300_0008, 32'h5555_AAAA, 4'h0, 2, 32'h0, 0, 1'b0);

    // Timeout with a late reply while waiting for rsp_ready
    txn(1'b0, 32'h0300_0010, 32'h0, 4'h0, 0, 32'h0, 4, 1'b1);
    // Boundary: reply exactly at the timeout cycle wins; one cycle later is an error
    txn(1'b0, 32'h0300_0014, 32'h0, 4'h0, int'(T), 32'h0BAD_C0DE, 0, 1'b0);
    txn(1'b0, 32'h0300_0018, 32'h0, 4'h0, int'(T) + 1, 32'h0BAD_C0DE, 0, 1'b0);

    // Stray ready in IDLE
    stray_cnt++;
    repeat (3) @(negedge clk);
    check("stray_idle", 32'({busy, rsp_valid, iomem_valid}), 32'd0);

    // Backpressure then two back-to-back reads
    txn(1'b0, 32'h0300_0020, 32'h0, 4'h0, 1, 32'h1111_0001, 10, 1'b0);
    txn(1'b0, 32'h0300_0024, 32'h0, 4'h0, 2, 32'h2222_0002, 0, 1'b0);
    txn(1'b0, 32'h0300_0028, 32'h0, 4'h0, 2, 32'h3333_0003, 0, 1'b0);

    // Reset mid-bus-cycle
    lat = 0;
    issue(1'b0, 32'h0300_0030, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("bus_before_reset", 32'(iomem_valid), 32'd1);
    resetn = 1'b0;
    #1;
    check("async_drop_valid", 32'(iomem_valid), 32'd0);
    check("async_idle", 32'({busy, rsp_valid, rsp_error}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    txn(1'b0, 32'h0300_0034, 32'h0, 4'h0, 2, 32'h7777_0007, 0, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      a = 32'h0300_0000 | {24'h0, 6'($urandom), 2'b00};
      txn(w, a, $urandom, s, int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got=hung expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/iomem_initiator.md
Name: iomem_initiator

Overview:
- Single-outstanding PicoSoC iomem bus master: the initiator end of the iomem protocol that the peripherals (LED/button GPIO and similar) respond to.
- Accepts one command on a valid/ready command port and runs one iomem read or write cycle.
- Returns rdata plus an error flag on a valid/ready response port.
- Timeout guard ends cycles to unresponsive or unmapped peripherals. Used by test harnesses and DMA-style helpers in place of the CPU.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles iomem_valid stays high without iomem_ready; 0 disables timeout.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when both high at posedge
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  32  target address
- cmd_wdata  input  32  write data
- cmd_wstrb  input  4  byte strobes, used only for writes
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when both high at posedge
- rsp_rdata  output  32  read data; 0 for writes and errors
- rsp_error  output  1  1=timeout or illegal command
- iomem_valid  output  1  bus request
- iomem_wstrb  output  4  0000=read, else write strobes
- iomem_addr  output  32  bus address
- iomem_wdata  output  32  bus write data
- iomem_ready  input  1  peripheral completion, single-cycle pulse
- iomem_rdata  input  32  peripheral read data, valid with iomem_ready
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values:
  - state=IDLE, iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, timeout counter=0
- Reset mid-operation: iomem_valid drops immediately (asynchronous), no response is produced, and the pending command is discarded.
- All outputs are registered except cmd_ready, which is (state==IDLE), and busy, which is (state!=IDLE).
- States: IDLE, BUS, RESP.
- IDLE, on cmd_valid:
  - Latch the command.
  - Illegal command (cmd_write=1 with cmd_wstrb=0000): no bus cycle. Go to RESP with rsp_error=1, rsp_rdata=0.
  - Otherwise: iomem_valid<=1, iomem_addr<=cmd_addr, iomem_wdata<=cmd_wdata.
  - iomem_wstrb<=cmd_write ? cmd_wstrb : 0000.
  - Counter<=0, go to BUS.
- BUS, request held stable:
  - iomem_valid, addr, wdata and wstrb stay constant until termination.
  - Termination, iomem_ready sampled high:
    - iomem_valid<=0 and iomem_wstrb<=0 at the same edge.
    - rsp_rdata<=(read ? iomem_rdata : 0), rsp_error<=0, rsp_valid<=1, go to RESP.
    - Dropping valid at that edge is mandatory, so the responder does not start a second cycle.
  - Timeout (TIMEOUT_CYCLES!=0, counter==TIMEOUT_CYCLES-1, iomem_ready low):
    - iomem_valid<=0, rsp_error<=1, rsp_rdata<=0, rsp_valid<=1, go to RESP.
    - If iomem_ready and the timeout hit in the same cycle, iomem_ready wins and there is no error.
  - Otherwise counter increments. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1, with no wrap before the timeout fires.
- RESP:
  - rsp_valid, rsp_rdata and rsp_error are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid<=0, go to IDLE.
  - A new command can be accepted on the cycle after the handshake (no bypass).
- A stray iomem_ready seen in IDLE or RESP (for example, a late reply after a timeout) is ignored and does not change state or data.
- Latency against a responder that asserts ready on the edge after it sees valid:
  - Command accepted at edge N.
  - iomem_ready high after N+1.
  - rsp_valid high after N+2.
- Throughput: at most one transaction every 4 cycles.

Decomposition:
- Shared package iomem_pkg:
  - state enum {IDLE, BUS, RESP}
  - IOMEM_ADDR_W=32, IOMEM_DATA_W=32, IOMEM_STRB_W=4
  - WSTRB_READ=4'b0000
- Sub-module iomem_timeout_ctr (parameter TIMEOUT_CYCLES; inputs clear and enable; output expired).
- FSM and datapath remain in iomem_initiator.

Test Plan:
- Read: cmd read addr=0x0300_0000; responder returns 0x0000_00A5 one cycle after valid -> iomem_wstrb=0000, rsp_rdata=0x0000_00A5, rsp_error=0, rsp_valid two edges after accept, iomem_valid high exactly 2 cycles.
- Full write: cmd write addr=0x0300_0000, wdata=0x0000_0001, wstrb=1111 -> iomem_wstrb=1111, wdata stable while valid, rsp_rdata=0, rsp_error=0; the responder sees exactly one ready pulse.
- Partial write and illegal write: wstrb=0010 -> iomem_wstrb=0010. Write with wstrb=0000 -> iomem_valid never rises, rsp_error=1 on the next cycle.
- Timeout: TIMEOUT_CYCLES=8, no responder -> iomem_valid high exactly 8 cycles, then rsp_error=1, rsp_rdata=0. Late iomem_ready 3 cycles later -> no state change.
- Backpressure and ordering:
  - Hold rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0, busy=1.
  - Release -> IDLE next cycle.
  - Two back-to-back reads return in order.
- Reset mid-BUS: deassert resetn while iomem_valid=1 -> iomem_valid=0 with no clock edge; after release, state is IDLE, rsp_valid=0, and a fresh read completes normally.
